// File: rtl/alu8_if.sv
// alu8 datapath bus: capture enable, opcode, operands, registered result and flags.
interface alu8_if;
   logic       en;
   logic [3:0] opcode;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] out;
   logic [3:0] flag;

   modport master (output en, opcode, a, b, input out, flag);
   modport slave  (input en, opcode, a, b, output out, flag);
endinterface

// File: rtl/alu8.sv
// alu8: 8-bit registered ALU, 16 opcodes, flags {C,Z,N,V} captured with the result.
module alu8 (
   input  logic   clk,
   input  logic   rst_n,
   alu8_if.slave  bus
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_XNOR = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_SAR  = 4'b1010;
   localparam logic [3:0] OP_ROL  = 4'b1011;
   localparam logic [3:0] OP_INC  = 4'b1100;
   localparam logic [3:0] OP_DEC  = 4'b1101;
   localparam logic [3:0] OP_CMP  = 4'b1110;
   localparam logic [3:0] OP_ROR  = 4'b1111;

   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [8:0] add_sum;
   logic [8:0] sub_dif;
   logic [8:0] inc_sum;
   logic [8:0] dec_dif;
   logic [7:0] res;
   logic [7:0] zn_src;
   logic       c_bit;
   logic       v_bit;
   logic [7:0] out_d;
   logic [7:0] out_q;
   logic [3:0] flag_d;
   logic [3:0] flag_q;

   assign op_a = bus.a;
   assign op_b = bus.b;

   // Result and flag computation; 9-bit sums expose carry/borrow in bit 8.
   always_comb begin
      add_sum = {1'b0, op_a} + {1'b0, op_b};
      sub_dif = {1'b0, op_a} - {1'b0, op_b};
      inc_sum = {1'b0, op_a} + 9'd1;
      dec_dif = {1'b0, op_a} - 9'd1;
      res     = '0;
      c_bit   = 1'b0;
      v_bit   = 1'b0;
      case (bus.opcode)
         OP_ADD: begin
            res   = add_sum[7:0];
            c_bit = add_sum[8];
            v_bit = (op_a[7] == op_b[7]) && (add_sum[7] != op_a[7]);
         end
         OP_SUB: begin
            res   = sub_dif[7:0];
            c_bit = sub_dif[8];
            v_bit = (op_a[7] != op_b[7]) && (sub_dif[7] != op_a[7]);
         end
         OP_AND:  res = op_a & op_b;
         OP_XOR:  res = op_a ^ op_b;
         OP_OR:   res = op_a | op_b;
         OP_NOR:  res = ~(op_a | op_b);
         OP_NAND: res = ~(op_a & op_b);
         OP_XNOR: res = ~(op_a ^ op_b);
         OP_SHL: begin
            res   = {op_a[6:0], 1'b0};
            c_bit = op_a[7];
         end
         OP_SHR: begin
            res   = {1'b0, op_a[7:1]};
            c_bit = op_a[0];
         end
         OP_SAR: begin
            res   = {op_a[7], op_a[7:1]};
            c_bit = op_a[0];
         end
         OP_ROL: begin
            res   = {op_a[6:0], op_a[7]};
            c_bit = op_a[7];
         end
         OP_INC: begin
            res   = inc_sum[7:0];
            c_bit = inc_sum[8];
            v_bit = !op_a[7] && inc_sum[7];
         end
         OP_DEC: begin
            res   = dec_dif[7:0];
            c_bit = dec_dif[8];
            v_bit = op_a[7] && !dec_dif[7];
         end
         OP_CMP: begin
            res   = op_a;
            c_bit = sub_dif[8];
            v_bit = (op_a[7] != op_b[7]) && (sub_dif[7] != op_a[7]);
         end
         default: begin
            res   = {op_a[0], op_a[7:1]};
            c_bit = op_a[0];
         end
      endcase
      // CMP passes A through but reports Z/N of A-B.
      zn_src = (bus.opcode == OP_CMP) ? sub_dif[7:0] : res;
      out_d  = out_q;
      flag_d = flag_q;
      if (bus.en) begin
         out_d  = res;
         flag_d = {c_bit, (zn_src == 8'h00), zn_src[7], v_bit};
      end
   end

   // Result/flag registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         flag_q <= '0;
      end else begin
         out_q  <= out_d;
         flag_q <= flag_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.flag = flag_q;

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: directed and random checks of alu8 against an arithmetic reference model.
module tb_alu8;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   logic [7:0] exp_out;
   logic [3:0] exp_flag;

   alu8_if bus ();

   alu8 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic from the opcode table; returns {flag, out}.
   function automatic logic [11:0] ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, s, ss, r, rz;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      c = 1'b0;
      v = 1'b0;
      r = 0;
      case (op)
         4'd0:  begin s = ua + ub; r = s % 256; c = (s > 255); ss = sa + sb; v = (ss > 127 || ss < -128); end
         4'd1, 4'd14: begin
            r = (ua - ub + 256) % 256; c = (ua < ub); ss = sa - sb; v = (ss > 127 || ss < -128);
         end
         4'd2:  r = int'(a & b);
         4'd3:  r = int'(a ^ b);
         4'd4:  r = int'(a | b);
         4'd5:  r = 255 - int'(a | b);
         4'd6:  r = 255 - int'(a & b);
         4'd7:  r = 255 - int'(a ^ b);
         4'd8:  begin r = (ua * 2) % 256; c = (ua >= 128); end
         4'd9:  begin r = ua / 2; c = (ua % 2 == 1); end
         4'd10: begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = (ua % 2 == 1); end
         4'd11: begin r = (ua * 2) % 256 + ua / 128; c = (ua >= 128); end
         4'd12: begin s = ua + 1; r = s % 256; c = (s > 255); v = (sa + 1 > 127); end
         4'd13: begin r = (ua + 255) % 256; c = (ua == 0); v = (sa - 1 < -128); end
         default: begin r = ua / 2 + (ua % 2) * 128; c = (ua % 2 == 1); end
      endcase
      rz = r;
      if (op == 4'd14) begin
         rz = r;
         r  = ua;
      end
      return {c, (rz == 0), (rz >= 128), v, 8'(r)};
   endfunction

   task automatic check(input string tag);
      n_assert++;
      assert (bus.out === exp_out && bus.flag === exp_flag)
      else begin
         n_fail++;
         $error("FAIL %s: out=%h flag=%b, expected out=%h flag=%b", tag, bus.out, bus.flag, exp_out, exp_flag);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.en = e;
      bus.opcode = op;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eo, input logic [3:0] ef, input string tag);
      drive(1'b1, op, a, b);
      exp_out  = eo;
      exp_flag = ef;
      check(tag);
   endtask

   task automatic rand_step(input logic e, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [11:0] m;
      drive(e, op, a, b);
      if (e) begin
         m = ref_model(op, a, b);
         exp_out  = m[7:0];
         exp_flag = m[11:8];
      end
      check($sformatf("rand op=%h a=%h b=%h en=%0b", op, a, b, e));
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.opcode = 4'd0;
      bus.a = 8'h12;
      bus.b = 8'h34;
      repeat (2) @(posedge clk);
      #1;
      exp_out  = 8'h00;
      exp_flag = 4'h0;
      check("reset");
      @(negedge clk);
      rst_n = 1'b1;

      directed(4'b0000, 8'h05, 8'h03, 8'h08, 4'b0000, "add_5_3");
      directed(4'b0001, 8'h05, 8'h07, 8'hFE, 4'b1010, "sub_5_7");
      directed(4'b0001, 8'h80, 8'h80, 8'h00, 4'b0100, "sub_80_80");
      directed(4'b0000, 8'hFF, 8'h01, 8'h00, 4'b1100, "add_ff_1");
      directed(4'b0010, 8'hF0, 8'h0F, 8'h00, 4'b0100, "and_f0_0f");
      directed(4'b0011, 8'h55, 8'hAA, 8'hFF, 4'b0010, "xor_55_aa");
      directed(4'b1111, 8'h01, 8'h00, 8'h80, 4'b1010, "ror_01");
      directed(4'b0000, 8'h7F, 8'h01, 8'h80, 4'b0011, "add_7f_1");
      directed(4'b1101, 8'h00, 8'h55, 8'hFF, 4'b1010, "dec_00");
      directed(4'b1101, 8'h80, 8'h00, 8'h7F, 4'b0001, "dec_80");
      directed(4'b1100, 8'h7F, 8'h00, 8'h80, 4'b0011, "inc_7f");
      directed(4'b1100, 8'hFF, 8'h00, 8'h00, 4'b1100, "inc_ff");
      directed(4'b1110, 8'h05, 8'h05, 8'h05, 4'b0100, "cmp_eq");
      directed(4'b1110, 8'h80, 8'h01, 8'h80, 4'b0001, "cmp_ovf");
      directed(4'b1010, 8'h81, 8'h00, 8'hC0, 4'b1010, "sar_81");
      directed(4'b1011, 8'h80, 8'h00, 8'h01, 4'b1000, "rol_80");

      // Hold with en=0 while inputs change
      drive(1'b0, 4'b0000, 8'h11, 8'h22);
      check("hold_en0_a");
      drive(1'b0, 4'b0101, 8'h00, 8'h00);
      check("hold_en0_b");

      // Async clear between edges, no clock edge needed
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_out  = 8'h00;
      exp_flag = 4'h0;
      check("async_clear");
      // Capture during reset is discarded
      bus.en = 1'b1;
      bus.opcode = 4'b0101;
      bus.a = 8'h00;
      bus.b = 8'h00;
      @(posedge clk);
      #1;
      check("reset_discard");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 48; i++) begin
         rand_step(($urandom_range(0, 4) != 0), 4'($urandom), 8'($urandom), 8'($urandom));
      end
      for (int op = 0; op < 16; op++) begin
         rand_step(1'b1, 4'(op), 8'($urandom), 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
